huffman_tree_param: RTL and testbench

//  Parametrised Huffman tree builder; NUM_SYM symbol counts loaded serially by valid/ready.

---
 rtl/huffman_tree_param_pkg.sv | 36 +++
 rtl/huffman_tree_param_min2_scan.sv | 86 ++++++++
 rtl/huffman_tree_param.sv | 190 +++++++++++++++++++
 tb/tb_huffman_tree_param.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_tree_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_tree_param_pkg
//  Description : Shared FSM encodings, node-table layout and clog2 helper for
//                the Huffman tree builder.
//  Revision    : 1.0 - initial release
// ============================================================================
package huffman_tree_param_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SCAN  = 3'd2;
    localparam logic [2:0] c_ST_MERGE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Leaves occupy slots [0, NUM_SYM); internal nodes follow from NUM_SYM.
    localparam int c_LEAF_BASE = 0;

    function automatic int internal_base(input int num_sym);
        return num_sym;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : huffman_tree_param_pkg
`default_nettype wire

// File: rtl/huffman_tree_param_min2_scan.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_tree_param_min2_scan
//  Description : Running two-minimum tracker; outputs include the current
//                input so the caller sees the result on the final slot cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module huffman_tree_param_min2_scan
    import huffman_tree_param_pkg::*;
#(
    parameter int IW = 5,
    parameter int WW = 13
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    input  logic [WW-1:0] i_weight,
    output logic [IW-1:0] o_min1_idx,
    output logic [WW-1:0] o_min1_weight,
    output logic          o_min1_valid,
    output logic [IW-1:0] o_min2_idx,
    output logic [WW-1:0] o_min2_weight,
    output logic          o_min2_valid
);

    logic [IW-1:0] r_min1_idx,    r_min2_idx;
    logic [WW-1:0] r_min1_weight, r_min2_weight;
    logic          r_min1_valid,  r_min2_valid;

    logic [IW-1:0] w_min1_idx,    w_min2_idx;
    logic [WW-1:0] w_min1_weight, w_min2_weight;
    logic          w_min1_valid,  w_min2_valid;

    // Strict '<' with ascending slot order keeps ties on the lower slot.
    always_comb begin
        w_min1_idx    = r_min1_idx;
        w_min1_weight = r_min1_weight;
        w_min1_valid  = r_min1_valid;
        w_min2_idx    = r_min2_idx;
        w_min2_weight = r_min2_weight;
        w_min2_valid  = r_min2_valid;
        if (i_valid) begin
            if (!r_min1_valid || (i_weight < r_min1_weight)) begin
                w_min2_idx    = r_min1_idx;
                w_min2_weight = r_min1_weight;
                w_min2_valid  = r_min1_valid;
                w_min1_idx    = i_idx;
                w_min1_weight = i_weight;
                w_min1_valid  = 1'b1;
            end else if (!r_min2_valid || (i_weight < r_min2_weight)) begin
                w_min2_idx    = i_idx;
                w_min2_weight = i_weight;
                w_min2_valid  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_min1_idx    <= '0;
            r_min1_weight <= '0;
            r_min1_valid  <= 1'b0;
            r_min2_idx    <= '0;
            r_min2_weight <= '0;
            r_min2_valid  <= 1'b0;
        end else begin
            r_min1_idx    <= w_min1_idx;
            r_min1_weight <= w_min1_weight;
            r_min1_valid  <= w_min1_valid;
            r_min2_idx    <= w_min2_idx;
            r_min2_weight <= w_min2_weight;
            r_min2_valid  <= w_min2_valid;
        end
    end

    assign o_min1_idx    = w_min1_idx;
    assign o_min1_weight = w_min1_weight;
    assign o_min1_valid  = w_min1_valid;
    assign o_min2_idx    = w_min2_idx;
    assign o_min2_weight = w_min2_weight;
    assign o_min2_valid  = w_min2_valid;

endmodule : huffman_tree_param_min2_scan
`default_nettype wire

// File: rtl/huffman_tree_param.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_tree_param
//  Description : Huffman tree builder by repeated two-minimum merges over a
//                (2*NUM_SYM-1)-slot node table. Define SKIP_ZERO_EN to drop
//                zero-count leaves from the tree.
//  Revision    : 1.0 - initial release
// ============================================================================
module huffman_tree_param
    import huffman_tree_param_pkg::*;
#(
    parameter int NUM_SYM = 10,
    parameter int CNT_W   = 9,
    parameter int IW      = clog2(2*NUM_SYM-1),
    parameter int WW      = CNT_W + clog2(NUM_SYM)
)(
    input  logic             Clk_in,
    input  logic             Rst,
    input  logic             Start_tree,
    input  logic             Sym_valid,
    output logic             Sym_ready,
    input  logic [CNT_W-1:0] Sym_cnt,
    output logic             Busy,
    output logic             Done,
    output logic             Err_empty,
    output logic [IW-1:0]    Node_cnt,
    output logic [IW-1:0]    Root,
    output logic [IW-1:0]    M1,
    output logic [IW-1:0]    M2,
    input  logic [IW-1:0]    Rd_addr,
    output logic [IW-1:0]    Rd_left,
    output logic [IW-1:0]    Rd_right,
    output logic [WW-1:0]    Rd_weight
);

    localparam int            c_SLOTS     = 2*NUM_SYM - 1;
    localparam logic [IW-1:0] c_LEAF0     = IW'(c_LEAF_BASE);
    localparam logic [IW-1:0] c_INT_BASE  = IW'(internal_base(NUM_SYM));
    localparam logic [IW-1:0] c_LAST_LEAF = IW'(NUM_SYM - 1);
    localparam logic [IW-1:0] c_LAST_SLOT = IW'(c_SLOTS - 1);
    localparam logic [IW-1:0] c_LAST_NODE = IW'(NUM_SYM - 2);

    logic [2:0]         r_state, w_state_nxt;
    logic [IW-1:0]      r_load_idx, r_scan_idx, r_node_cnt;
    logic [IW-1:0]      r_root, r_m1, r_m2;
    logic               r_err_empty;
    logic [c_SLOTS-1:0] r_active;
    logic [WW-1:0]      r_weight [c_SLOTS];
    logic [IW-1:0]      r_left   [c_SLOTS];
    logic [IW-1:0]      r_right  [c_SLOTS];

    logic               w_sym_ready, w_busy, w_done;
    logic               w_accept, w_leaf_active;
    logic               w_scan_valid, w_scan_clear, w_scan_last, w_two;
    logic [IW-1:0]      w_merge_slot, w_rd_slot;
    logic               w_rd_ok;
    logic [IW-1:0]      w_min1_idx, w_min2_idx;
    logic [WW-1:0]      w_min1_weight, w_min2_weight;
    logic               w_min1_valid, w_min2_valid;

`ifdef SKIP_ZERO_EN
    assign w_leaf_active = |Sym_cnt;
`else
    assign w_leaf_active = 1'b1;
`endif

    assign w_accept     = (r_state == c_ST_LOAD) && Sym_valid;
    assign w_scan_valid = (r_state == c_ST_SCAN) && r_active[r_scan_idx];
    assign w_scan_clear = (r_state != c_ST_SCAN);
    assign w_scan_last  = (r_scan_idx == c_LAST_SLOT);
    assign w_two        = w_min1_valid && w_min2_valid;
    assign w_merge_slot = c_INT_BASE + r_node_cnt;

    huffman_tree_param_min2_scan #(
        .IW (IW),
        .WW (WW)
    ) u_min2_scan (
        .clk           (Clk_in),
        .rst           (Rst),
        .i_clear       (w_scan_clear),
        .i_valid       (w_scan_valid),
        .i_idx         (r_scan_idx),
        .i_weight      (r_weight[r_scan_idx]),
        .o_min1_idx    (w_min1_idx),
        .o_min1_weight (w_min1_weight),
        .o_min1_valid  (w_min1_valid),
        .o_min2_idx    (w_min2_idx),
        .o_min2_weight (w_min2_weight),
        .o_min2_valid  (w_min2_valid)
    );

    always_ff @(posedge Clk_in) begin
        if (Rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sym_ready = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
                if (Start_tree) w_state_nxt = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_sym_ready = 1'b1;
                if (w_accept && (r_load_idx == c_LAST_LEAF)) w_state_nxt = c_ST_SCAN;
            end
            c_ST_SCAN: begin
                // Tracker outputs already include the last slot here.
                if (w_scan_last) w_state_nxt = w_two ? c_ST_MERGE : c_ST_DONE;
            end
            c_ST_MERGE: w_state_nxt = c_ST_SCAN;
            c_ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (Rst || ((r_state == c_ST_IDLE) && Start_tree)) begin
            r_load_idx  <= '0;
            r_scan_idx  <= '0;
            r_node_cnt  <= '0;
            r_root      <= '0;
            r_m1        <= '0;
            r_m2        <= '0;
            r_err_empty <= 1'b0;
            r_active    <= '0;
            for (int i = 0; i < c_SLOTS; i++) begin
                r_weight[i] <= '0;
                r_left[i]   <= '0;
                r_right[i]  <= '0;
            end
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (Sym_valid) begin
                        r_weight[c_LEAF0 + r_load_idx] <= WW'(Sym_cnt);
                        r_active[c_LEAF0 + r_load_idx] <= w_leaf_active;
                        r_load_idx                     <= r_load_idx + 1'b1;
                    end
                end
                c_ST_SCAN: begin
                    r_scan_idx <= w_scan_last ? '0 : r_scan_idx + 1'b1;
                    if (w_scan_last && !w_two) begin
                        r_root      <= w_min1_valid ? w_min1_idx : '0;
                        r_err_empty <= (r_node_cnt == '0);
                    end
                end
                c_ST_MERGE: begin
                    r_weight[w_merge_slot] <= w_min1_weight + w_min2_weight;
                    r_left[w_merge_slot]   <= w_min1_idx;
                    r_right[w_merge_slot]  <= w_min2_idx;
                    r_active[w_min1_idx]   <= 1'b0;
                    r_active[w_min2_idx]   <= 1'b0;
                    r_active[w_merge_slot] <= 1'b1;
                    r_m1                   <= w_min1_idx;
                    r_m2                   <= w_min2_idx;
                    r_node_cnt             <= r_node_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_rd_ok   = (Rd_addr <= c_LAST_NODE);
    assign w_rd_slot = c_INT_BASE + Rd_addr;
    assign Rd_left   = w_rd_ok ? r_left[w_rd_slot]   : '0;
    assign Rd_right  = w_rd_ok ? r_right[w_rd_slot]  : '0;
    assign Rd_weight = w_rd_ok ? r_weight[w_rd_slot] : '0;

    assign Sym_ready = w_sym_ready;
    assign Busy      = w_busy;
    assign Done      = w_done;
    assign Err_empty = r_err_empty;
    assign Node_cnt  = r_node_cnt;
    assign Root      = r_root;
    assign M1        = r_m1;
    assign M2        = r_m2;

endmodule : huffman_tree_param
`default_nettype wire

// File: tb/tb_huffman_tree_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huffman_tree_param
//  Description : Self-checking bench for huffman_tree_param (NUM_SYM=10 and
//                NUM_SYM=4 instances) against a sorted-queue Huffman model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_tree_param;

`ifdef SKIP_ZERO_EN
    localparam bit c_SKIP = 1'b1;
`else
    localparam bit c_SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [9:0][8:0] cnt;
        logic            toggle;
        logic            poke;
        logic [4:0]      root;
        logic [12:0]     root_w;
        logic [4:0]      nc;
        logic            err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_valid = 1'b0;
    logic [8:0]  a_cnt = '0;
    logic [4:0]  a_rd_addr = '0;
    logic        a_ready, a_busy, a_done, a_err;
    logic [4:0]  a_nc, a_root, a_m1, a_m2, a_left, a_right;
    logic [12:0] a_weight;

    logic        b_start = 1'b0, b_valid = 1'b0;
    logic [8:0]  b_cnt = '0;
    logic [2:0]  b_rd_addr = '0;
    logic        b_ready, b_busy, b_done, b_err;
    logic [2:0]  b_nc, b_root, b_m1, b_m2, b_left, b_right;
    logic [11:0] b_weight;

    int n_vec = 0;
    int n_err = 0;

    int e_left[9], e_right[9], e_w[9];
    int e_root, e_nc, e_err, e_lat;
    int mq[$];

    always #5 clk = ~clk;

    huffman_tree_param #(.NUM_SYM(10), .CNT_W(9)) dut_a (
        .Clk_in(clk), .Rst(rst), .Start_tree(a_start), .Sym_valid(a_valid),
        .Sym_ready(a_ready), .Sym_cnt(a_cnt), .Busy(a_busy), .Done(a_done),
        .Err_empty(a_err), .Node_cnt(a_nc), .Root(a_root), .M1(a_m1), .M2(a_m2),
        .Rd_addr(a_rd_addr), .Rd_left(a_left), .Rd_right(a_right), .Rd_weight(a_weight)
    );

    huffman_tree_param #(.NUM_SYM(4), .CNT_W(9)) dut_b (
        .Clk_in(clk), .Rst(rst), .Start_tree(b_start), .Sym_valid(b_valid),
        .Sym_ready(b_ready), .Sym_cnt(b_cnt), .Busy(b_busy), .Done(b_done),
        .Err_empty(b_err), .Node_cnt(b_nc), .Root(b_root), .M1(b_m1), .M2(b_m2),
        .Rd_addr(b_rd_addr), .Rd_left(b_left), .Rd_right(b_right), .Rd_weight(b_weight)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sorted insert keyed by weight*32+slot: lowest weight first, ties to lower slot.
    function automatic void ins(input int key);
        int i;
        i = 0;
        while (i < mq.size() && mq[i] < key) i++;
        mq.insert(i, key);
    endfunction

    task automatic model(input logic [9:0][8:0] cnt);
        int a, b, m;
        mq = {};
        for (int k = 0; k < 10; k++)
            if (!c_SKIP || cnt[k] != 0) ins(int'(cnt[k]) * 32 + k);
        m = 0;
        while (mq.size() >= 2) begin
            a = mq.pop_front();
            b = mq.pop_front();
            e_left[m]  = a % 32;
            e_right[m] = b % 32;
            e_w[m]     = a / 32 + b / 32;
            ins(e_w[m] * 32 + 10 + m);
            m++;
        end
        e_root = (mq.size() == 1) ? mq[0] % 32 : 0;
        e_nc   = m;
        e_err  = (m == 0) ? 1 : 0;
        e_lat  = 2 * 10 * (m + 1);
    endtask

    task automatic run_a(input logic [9:0][8:0] cnt, input logic toggle, input logic poke,
                         input int abort_at);
        int k, lat, guard;
        model(cnt);
        @(negedge clk);
        a_start = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        k = 0;
        guard = 0;
        while (k < 10 && guard < 1000) begin
            a_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            a_cnt   = a_valid ? cnt[k] : 9'($urandom);
            a_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (a_valid && a_ready) k++;
            @(negedge clk);
            guard++;
        end
        chk("load_accepts", 32'(k), 32'd10);
        chk("ready_after_load", 32'(a_ready), 32'd0);
        lat = 1;
        while (!a_done && lat < 5000) begin
            a_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            a_valid = 1'($urandom_range(0, 1));
            a_cnt   = 9'($urandom);
            @(negedge clk);
            lat++;
            if (abort_at != 0 && lat == abort_at) begin
                chk("busy_pre_rst", 32'(a_busy), 32'd1);
                chk("node_cnt_pre_rst", 32'(a_nc), 32'd1);
                a_start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("busy_after_rst", 32'(a_busy), 32'd0);
                chk("node_cnt_after_rst", 32'(a_nc), 32'd0);
                chk("ready_after_rst", 32'(a_ready), 32'd0);
                a_rd_addr = 5'd0;
                #1;
                chk("weight_after_rst", 32'(a_weight), 32'd0);
                return;
            end
        end
        a_start = 1'b0;
        a_valid = 1'b0;
        chk("done_seen", 32'(a_done), 32'd1);
        chk("latency", 32'(lat), 32'(e_lat));
        chk("err_empty", 32'(a_err), 32'(e_err));
        chk("node_cnt", 32'(a_nc), 32'(e_nc));
        chk("root", 32'(a_root), 32'(e_root));
        if (e_nc > 0) begin
            chk("m1", 32'(a_m1), 32'(e_left[e_nc-1]));
            chk("m2", 32'(a_m2), 32'(e_right[e_nc-1]));
        end
        @(negedge clk);
        chk("done_pulse_end", 32'(a_done), 32'd0);
        chk("busy_idle", 32'(a_busy), 32'd0);
        chk("err_hold", 32'(a_err), 32'(e_err));
        chk("root_hold", 32'(a_root), 32'(e_root));
        for (int m = 0; m < e_nc; m++) begin
            a_rd_addr = 5'(m);
            #1;
            chk("rd_left", 32'(a_left), 32'(e_left[m]));
            chk("rd_right", 32'(a_right), 32'(e_right[m]));
            chk("rd_weight", 32'(a_weight), 32'(e_w[m]));
        end
    endtask

    function automatic vec_t mk(input logic [9:0][8:0] c, input logic tg, input logic pk,
                                input logic [4:0] rt, input logic [12:0] rw,
                                input logic [4:0] nc, input logic er);
        vec_t v;
        v.cnt = c; v.toggle = tg; v.poke = pk;
        v.root = rt; v.root_w = rw; v.nc = nc; v.err = er;
        return v;
    endfunction

    initial begin
        vec_t tbl[4];
        logic [9:0][8:0] c1, rc;
        int bl[3], br[3], bw[3];
        int k, lat, guard;

        c1 = {9'd39, 9'd4, 9'd12, 9'd7, 9'd23, 9'd38, 9'd14, 9'd26, 9'd40, 9'd53};
        tbl[0] = mk(c1, 1'b0, 1'b0, 5'd18, 13'd256, 5'd9, 1'b0);
`ifdef SKIP_ZERO_EN
        tbl[1] = mk({{9{9'd0}}, 9'd256}, 1'b0, 1'b0, 5'd0, 13'd0, 5'd0, 1'b1);
`else
        tbl[1] = mk({{9{9'd0}}, 9'd256}, 1'b0, 1'b0, 5'd18, 13'd256, 5'd9, 1'b0);
`endif
        tbl[2] = mk({10{9'd511}}, 1'b0, 1'b0, 5'd18, 13'd5110, 5'd9, 1'b0);
        tbl[3] = mk(c1, 1'b1, 1'b1, 5'd18, 13'd256, 5'd9, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_node_cnt", 32'(a_nc), 32'd0);
        chk("rst_root", 32'(a_root), 32'd0);
        chk("rst_m1m2", 32'({a_m1, a_m2}), 32'd0);
        chk("rst_rd_weight", 32'(a_weight), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_a(tbl[i].cnt, tbl[i].toggle, tbl[i].poke, 0);
            chk("tbl_root", 32'(a_root), 32'(tbl[i].root));
            chk("tbl_node_cnt", 32'(a_nc), 32'(tbl[i].nc));
            chk("tbl_err", 32'(a_err), 32'(tbl[i].err));
            if (tbl[i].nc != 0) begin
                a_rd_addr = tbl[i].nc - 5'd1;
                #1;
                chk("tbl_root_weight", 32'(a_weight), 32'(tbl[i].root_w));
            end
            if (i == 0) begin
                a_rd_addr = 5'd0; #1;
                chk("node0", 32'({a_left, a_right, a_weight}), 32'({5'd8, 5'd6, 13'd11}));
                a_rd_addr = 5'd1; #1;
                chk("node1", 32'({a_left, a_right, a_weight}), 32'({5'd10, 5'd7, 13'd23}));
                a_rd_addr = 5'd2; #1;
                chk("node2", 32'({a_left, a_right, a_weight}), 32'({5'd3, 5'd5, 13'd37}));
            end
        end

        run_a(c1, 1'b0, 1'b0, 30);
        run_a(c1, 1'b0, 1'b0, 0);
        chk("rebuild_root_weight", 32'(e_w[8]), 32'd256);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 10; j++) begin
                if (r == 5)
                    rc[j] = (j == 2 || j == 7) ? 9'($urandom_range(1, 511)) : 9'd0;
                else
                    rc[j] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            end
            run_a(rc, 1'(r[0]), 1'(r[1]), 0);
        end

        bl = '{0, 2, 4}; br = '{1, 3, 5}; bw = '{2, 2, 4};
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 100) begin
            b_valid = 1'b1;
            b_cnt   = 9'd1;
            #1;
            if (b_ready) k++;
            @(negedge clk);
            guard++;
        end
        b_valid = 1'b0;
        lat = 1;
        while (!b_done && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk("b_latency", 32'(lat), 32'd32);
        chk("b_root", 32'(b_root), 32'd6);
        chk("b_node_cnt", 32'(b_nc), 32'd3);
        chk("b_err", 32'(b_err), 32'd0);
        for (int m = 0; m < 3; m++) begin
            b_rd_addr = 3'(m);
            #1;
            chk("b_node", 32'({b_left, b_right, b_weight}), 32'({3'(bl[m]), 3'(br[m]), 12'(bw[m])}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_huffman_tree_param
`default_nettype wire
